// File: rtl/ws_writeback_if.sv
// Bus bundle for ws_writeback: start/done handshake, S RAM read port and SRAM write port.
// The master modport is taken by the writeback engine, the slave modport by its environment.
interface ws_writeback_if;
  logic        WS_start;
  logic        WS_done;
  logic [1:0]  Seg_sel;
  logic [4:0]  RB;
  logic [5:0]  CB;
  logic [6:0]  S_read_address;
  logic [31:0] S_read_data;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;

  modport master (
    input  WS_start, Seg_sel, RB, CB, S_read_data,
    output WS_done, S_read_address, SRAM_address, SRAM_write_data, SRAM_we_n
  );

  modport slave (
    output WS_start, Seg_sel, RB, CB, S_read_data,
    input  WS_done, S_read_address, SRAM_address, SRAM_write_data, SRAM_we_n
  );
endinterface

// File: rtl/ws_writeback.sv
// Writes one 8x8 S block back to SRAM as 32 packed pixel pairs (Y/U/V segment addressing).
// Optional macro WS_CLIP_EN: saturate S to 0..255 instead of truncating to S[7:0].
module ws_writeback (
  input  logic            CLOCK_50_I,
  input  logic            Reset,
  ws_writeback_if.master  ws
);

  typedef enum logic [2:0] {
    S_WS_IDLE,
    S_WS_RD_EVEN,
    S_WS_RD_ODD,
    S_WS_FLUSH,
    S_WS_DONE
  } ws_state_t;

  ws_state_t   state, next_state;
  logic        flush_cnt;
  logic [1:0]  seg_q;
  logic [4:0]  rb_q;
  logic [5:0]  cb_q;
  logic        arr_valid;
  logic [5:0]  arr_idx;
  logic [7:0]  even_q;
  logic [7:0]  pix;
  logic [7:0]  row;
  logic [7:0]  col;
  logic [17:0] base;
  logic [17:0] stride_term;
  logic [17:0] word_addr;
  logic        unused_bits;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_WS_IDLE:    if (ws.WS_start) next_state = S_WS_RD_EVEN;
      S_WS_RD_EVEN: next_state = S_WS_RD_ODD;
      S_WS_RD_ODD:  next_state = (ws.S_read_address == 7'd63) ? S_WS_FLUSH : S_WS_RD_EVEN;
      S_WS_FLUSH:   if (flush_cnt) next_state = S_WS_DONE;
      S_WS_DONE:    next_state = S_WS_IDLE;
      default:      next_state = S_WS_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) state <= S_WS_IDLE;
    else       state <= next_state;
  end

  always_comb begin
`ifdef WS_CLIP_EN
    if (ws.S_read_data[31])          pix = 8'h00;
    else if (|ws.S_read_data[30:8])  pix = 8'hFF;
    else                             pix = ws.S_read_data[7:0];
`else
    pix = ws.S_read_data[7:0];
`endif
  end

`ifdef WS_CLIP_EN
  assign unused_bits = ws.S_read_address[6];
`else
  assign unused_bits = ^{ws.S_read_address[6], ws.S_read_data[31:8]};
`endif

  // Stride multiplies as shift-add: 160 = 128 + 32, 80 = 64 + 16.
  always_comb begin
    row = {rb_q, arr_idx[5:3]};
    col = {cb_q, arr_idx[2:1]};
    case (seg_q)
      2'd1: begin
        base        = 18'd38400;
        stride_term = {4'b0, row, 6'b0} + {6'b0, row, 4'b0};
      end
      2'd2: begin
        base        = 18'd57600;
        stride_term = {4'b0, row, 6'b0} + {6'b0, row, 4'b0};
      end
      default: begin
        base        = 18'd0;
        stride_term = {3'b0, row, 7'b0} + {5'b0, row, 5'b0};
      end
    endcase
    word_addr = base + stride_term + {10'b0, col};
  end

  always_ff @(posedge CLOCK_50_I or posedge Reset) begin
    if (Reset) begin
      seg_q              <= 2'd0;
      rb_q               <= 5'd0;
      cb_q               <= 6'd0;
      flush_cnt          <= 1'b0;
      arr_valid          <= 1'b0;
      arr_idx            <= 6'd0;
      even_q             <= 8'd0;
      ws.S_read_address  <= 7'd0;
      ws.SRAM_address    <= 18'd0;
      ws.SRAM_write_data <= 16'd0;
      ws.SRAM_we_n       <= 1'b1;
      ws.WS_done         <= 1'b0;
    end else begin
      if (state == S_WS_IDLE && ws.WS_start) begin
        seg_q             <= ws.Seg_sel;
        rb_q              <= ws.RB;
        cb_q              <= ws.CB;
        ws.S_read_address <= 7'd0;
      end else if (state == S_WS_RD_EVEN ||
                   (state == S_WS_RD_ODD && ws.S_read_address != 7'd63)) begin
        ws.S_read_address <= ws.S_read_address + 7'd1;
      end

      flush_cnt <= (state == S_WS_FLUSH) ? ~flush_cnt : 1'b0;

      // Data on S_read_data always belongs to the address presented one cycle earlier.
      arr_valid <= (state == S_WS_RD_EVEN) || (state == S_WS_RD_ODD);
      arr_idx   <= ws.S_read_address[5:0];

      if (arr_valid && !arr_idx[0]) even_q <= pix;

      if (arr_valid && arr_idx[0]) begin
        ws.SRAM_address    <= word_addr;
        ws.SRAM_write_data <= {even_q, pix};
        ws.SRAM_we_n       <= 1'b0;
      end else begin
        ws.SRAM_we_n       <= 1'b1;
      end

      ws.WS_done <= (next_state == S_WS_DONE);
    end
  end

endmodule

// File: tb/tb_ws_writeback.sv
// Self-checking bench for ws_writeback: table of block writebacks plus restart, reset-abort
// and back-to-back sequences. Expected pixels follow WS_CLIP_EN when it is defined.
module tb_ws_writeback;

  logic CLOCK_50_I = 1'b0;
  logic Reset;

  ws_writeback_if ws ();

  ws_writeback dut (
    .CLOCK_50_I (CLOCK_50_I),
    .Reset      (Reset),
    .ws         (ws)
  );

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  // S dual-port RAM model: registered read, data one cycle after its address.
  logic signed [31:0] s_mem [64];
  always @(posedge CLOCK_50_I) ws.S_read_data <= s_mem[ws.S_read_address[5:0]];

  typedef struct {
    logic [1:0]  seg;
    logic [4:0]  rb;
    logic [5:0]  cb;
    int          pat;
    logic [17:0] a_first;
    logic [15:0] d_first;
    logic [17:0] a_last;
    logic [15:0] d_last;
  } vec_t;

  vec_t vecs [6];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix_m(input int s);
`ifdef WS_CLIP_EN
    if (s < 0)   return 8'h00;
    if (s > 255) return 8'hFF;
`endif
    return s[7:0];
  endfunction

  function automatic logic [17:0] addr_m(input logic [1:0] seg, input int rb, input int cb, input int k);
    int          base, stride;
    logic [31:0] a;
    case (seg)
      2'd1:    begin base = 38400; stride = 80;  end
      2'd2:    begin base = 57600; stride = 80;  end
      default: begin base = 0;     stride = 160; end
    endcase
    a = base + (8 * rb + k / 4) * stride + 4 * cb + k % 4;
    return a[17:0];
  endfunction

  task automatic fill(input int pat);
    for (int i = 0; i < 64; i++) begin
      case (pat)
        1:       s_mem[i] = 100;
        2:       s_mem[i] = (i == 0) ? -5 : (i == 1) ? 300 : i;
        default: s_mem[i] = i;
      endcase
    end
  endtask

  // Runs one block from a start in cycle 0 through cycle 67; returns at the middle of cycle 67.
  task automatic run_block(input vec_t v, input int id, input bit restart10);
    int writes = 0;
    int dones  = 0;
    int k;
    @(negedge CLOCK_50_I);
    check($sformatf("b%0d_pre_we_n", id), ws.SRAM_we_n, 1);
    check($sformatf("b%0d_pre_done", id), ws.WS_done, 0);
    fill(v.pat);
    ws.WS_start = 1'b1;
    ws.Seg_sel  = v.seg;
    ws.RB       = v.rb;
    ws.CB       = v.cb;
    for (int cyc = 1; cyc <= 67; cyc++) begin
      @(negedge CLOCK_50_I);
      if (cyc <= 64)
        check($sformatf("b%0d_rd_addr_c%0d", id, cyc), ws.S_read_address, cyc - 1);
      if (!ws.SRAM_we_n) begin
        k = writes;
        writes++;
        check($sformatf("b%0d_wr_cycle_k%0d", id, k), cyc, 2 * k + 4);
        if (k < 32) begin
          check($sformatf("b%0d_addr_k%0d", id, k), ws.SRAM_address,
                addr_m(v.seg, v.rb, v.cb, k));
          check($sformatf("b%0d_data_k%0d", id, k), ws.SRAM_write_data,
                {pix_m(s_mem[2 * k]), pix_m(s_mem[2 * k + 1])});
        end
        if (k == 0) begin
          check($sformatf("b%0d_first_addr", id), ws.SRAM_address, v.a_first);
          check($sformatf("b%0d_first_data", id), ws.SRAM_write_data, v.d_first);
        end
        if (k == 31) begin
          check($sformatf("b%0d_last_addr", id), ws.SRAM_address, v.a_last);
          check($sformatf("b%0d_last_data", id), ws.SRAM_write_data, v.d_last);
        end
      end
      if (ws.WS_done) begin
        dones++;
        check($sformatf("b%0d_done_cycle", id), cyc, 67);
      end
      // Scrambled inputs after the start must not disturb the latched block parameters.
      if (cyc == 1) begin
        ws.WS_start = 1'b0;
        ws.Seg_sel  = ~v.seg;
        ws.RB       = ~v.rb;
        ws.CB       = ~v.cb;
      end
      if (cyc == 10 && restart10) ws.WS_start = 1'b1;
      if (cyc == 11) ws.WS_start = 1'b0;
    end
    check($sformatf("b%0d_write_count", id), writes, 32);
    check($sformatf("b%0d_done_count", id), dones, 1);
  endtask

  // Idle after a block: no writes, no done, address/data hold the last word.
  task automatic idle_check(input vec_t v, input int id);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50_I);
      check($sformatf("b%0d_idle_we_n", id), ws.SRAM_we_n, 1);
      check($sformatf("b%0d_idle_done", id), ws.WS_done, 0);
      check($sformatf("b%0d_idle_addr", id), ws.SRAM_address, v.a_last);
      check($sformatf("b%0d_idle_data", id), ws.SRAM_write_data, v.d_last);
    end
  endtask

  initial begin
    int nwr, ndone;
    vecs[0] = '{2'd0, 5'd0,  6'd0,  0, 18'd0,     16'h0001, 18'd1123,  16'h3E3F};
    vecs[1] = '{2'd2, 5'd29, 6'd19, 1, 18'd76236, 16'h6464, 18'd76799, 16'h6464};
    vecs[2] = '{2'd1, 5'd1,  6'd2,  0, 18'd39048, 16'h0001, 18'd39611, 16'h3E3F};
    vecs[3] = '{2'd3, 5'd2,  6'd39, 0, 18'd2716,  16'h0001, 18'd3839,  16'h3E3F};
`ifdef WS_CLIP_EN
    vecs[4] = '{2'd0, 5'd0,  6'd0,  2, 18'd0,     16'h00FF, 18'd1123,  16'h3E3F};
`else
    vecs[4] = '{2'd0, 5'd0,  6'd0,  2, 18'd0,     16'hFB2C, 18'd1123,  16'h3E3F};
`endif
    vecs[5] = '{2'd2, 5'd31, 6'd63, 1, 18'd77692, 16'h6464, 18'd78255, 16'h6464};

    Reset       = 1'b1;
    ws.WS_start = 1'b0;
    ws.Seg_sel  = 2'd0;
    ws.RB       = 5'd0;
    ws.CB       = 6'd0;
    fill(0);
    repeat (3) @(negedge CLOCK_50_I);
    check("rst_we_n",    ws.SRAM_we_n, 1);
    check("rst_done",    ws.WS_done, 0);
    check("rst_addr",    ws.SRAM_address, 0);
    check("rst_data",    ws.SRAM_write_data, 0);
    check("rst_rd_addr", ws.S_read_address, 0);
    Reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_block(vecs[i], i, 1'b0);
      idle_check(vecs[i], i);
    end

    // Second start in cycle 10 is ignored.
    run_block(vecs[0], 10, 1'b1);
    idle_check(vecs[0], 10);

    // Back-to-back: the second start lands in the cycle right after WS_done.
    run_block(vecs[1], 11, 1'b0);
    run_block(vecs[2], 12, 1'b0);
    idle_check(vecs[2], 12);

    // Reset in cycle 20 aborts the block.
    @(negedge CLOCK_50_I);
    fill(0);
    ws.WS_start = 1'b1;
    ws.Seg_sel  = 2'd0;
    ws.RB       = 5'd0;
    ws.CB       = 6'd0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge CLOCK_50_I);
      if (cyc == 1) ws.WS_start = 1'b0;
    end
    check("abort_we_before", ws.SRAM_we_n, 0);
    Reset = 1'b1;
    #1;
    check("abort_we_n",    ws.SRAM_we_n, 1);
    check("abort_done",    ws.WS_done, 0);
    check("abort_addr",    ws.SRAM_address, 0);
    check("abort_data",    ws.SRAM_write_data, 0);
    check("abort_rd_addr", ws.S_read_address, 0);
    nwr   = 0;
    ndone = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge CLOCK_50_I);
      if (cyc == 5) Reset = 1'b0;
      if (!ws.SRAM_we_n) nwr++;
      if (ws.WS_done)    ndone++;
    end
    check("abort_no_write", nwr, 0);
    check("abort_no_done",  ndone, 0);
    run_block(vecs[0], 13, 1'b0);
    idle_check(vecs[0], 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
